// File: rtl/imm_gen_pkg.sv
// Shared types for the pipelined immediate generator: immediate format tags,
// skid-buffer states and the RV opcodes the decoder recognises.
package imm_gen_pkg;

    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_SHAMT = 3'd2,
        FMT_S     = 3'd3,
        FMT_B     = 3'd4,
        FMT_U     = 3'd5,
        FMT_J     = 3'd6,
        FMT_CSR   = 3'd7
    } fmt_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } skid_state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

endpackage

// File: rtl/imm_decode_lane.sv
// Combinational single-lane immediate decode: extracts and extends the
// immediate, tags its format and forms the PC-relative target.
module imm_decode_lane
    import imm_gen_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int EN_CSR = 1
) (
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic [XLEN-1:0] target
);

    function automatic logic signed [XLEN-1:0] sext32(input logic signed [31:0] v);
        return XLEN'(v);
    endfunction

    function automatic logic [XLEN-1:0] zext6(input logic [5:0] v);
        return XLEN'(v);
    endfunction

    logic [6:0]             opcode;
    logic [2:0]             funct3;
    logic signed [XLEN-1:0] imm_s;
    fmt_t                   fmt_d;
    logic                   use_pc;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];

    always_comb begin
        imm_s  = '0;
        fmt_d  = FMT_NONE;
        use_pc = 1'b0;
        case (opcode)
            OP_LOAD, OP_JALR: begin
                fmt_d = FMT_I;
                imm_s = sext32({{20{instr[31]}}, instr[31:20]});
            end
            OP_IMM: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    // RV64 shifts carry a 6-bit shamt; bit 25 belongs to funct7 on RV32
                    fmt_d = FMT_SHAMT;
                    imm_s = (XLEN == 64) ? zext6(instr[25:20]) : zext6({1'b0, instr[24:20]});
                end else begin
                    fmt_d = FMT_I;
                    imm_s = sext32({{20{instr[31]}}, instr[31:20]});
                end
            end
            OP_STORE: begin
                fmt_d = FMT_S;
                imm_s = sext32({{20{instr[31]}}, instr[31:25], instr[11:7]});
            end
            OP_BRANCH: begin
                fmt_d  = FMT_B;
                use_pc = 1'b1;
                imm_s  = sext32({{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                                 instr[11:8], 1'b0});
            end
            OP_LUI, OP_AUIPC: begin
                fmt_d  = FMT_U;
                use_pc = (opcode == OP_AUIPC);
                imm_s  = sext32({instr[31:12], 12'b0});
            end
            OP_JAL: begin
                fmt_d  = FMT_J;
                use_pc = 1'b1;
                imm_s  = sext32({{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                                 instr[30:21], 1'b0});
            end
            OP_SYSTEM: begin
                if (instr[14] && EN_CSR != 0) begin
                    fmt_d = FMT_CSR;
                    imm_s = zext6({1'b0, instr[19:15]});
                end
            end
            default: ;
        endcase
    end

    assign imm    = imm_s;
    assign fmt    = fmt_d;
    assign target = use_pc ? pc + imm_s : '0;

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined multi-lane immediate generator: per-lane decode feeding one
// register stage wrapped in a valid/ready skid buffer.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int N_LANES = 1,
    parameter int EN_CSR  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [32*N_LANES-1:0]   in_instr,
    input  logic [XLEN-1:0]         in_pc,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN*N_LANES-1:0] out_imm,
    output logic [3*N_LANES-1:0]    out_fmt,
    output logic [XLEN*N_LANES-1:0] out_target
);

    logic [XLEN*N_LANES-1:0] imm_p0, tgt_p0;
    logic [3*N_LANES-1:0]    fmt_p0;

    for (genvar k = 0; k < N_LANES; k++) begin : g_lane
        imm_decode_lane #(
            .XLEN   (XLEN),
            .EN_CSR (EN_CSR)
        ) u_lane (
            .instr  (in_instr[32*k +: 32]),
            .pc     (in_pc + XLEN'(4*k)),
            .imm    (imm_p0[XLEN*k +: XLEN]),
            .fmt    (fmt_p0[3*k +: 3]),
            .target (tgt_p0[XLEN*k +: XLEN])
        );
    end

    // ---- stage p0 -> p1: skid buffer control ----
    skid_state_t state, state_nxt;
    logic        accept, drain, vld_p1;
    logic        load_main, load_skid, pop_skid;

    assign vld_p1   = (state != ST_EMPTY);
    assign in_ready = rst_n && (state != ST_SKID);
    assign accept   = in_valid && in_ready;
    assign drain    = vld_p1 && out_ready;

    always_comb begin
        state_nxt = state;
        load_main = 1'b0;
        load_skid = 1'b0;
        pop_skid  = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    state_nxt = ST_FULL;
                    load_main = 1'b1;
                end
            end
            ST_FULL: begin
                if (accept && !drain) begin
                    state_nxt = ST_SKID;
                    load_skid = 1'b1;
                end else if (accept) begin
                    load_main = 1'b1;
                end else if (drain) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_SKID: begin
                if (drain) begin
                    state_nxt = ST_FULL;
                    pop_skid  = 1'b1;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_EMPTY;
        else        state <= state_nxt;
    end

    // ---- stage p1: main and skid data registers ----
    logic [XLEN*N_LANES-1:0] imm_p1, tgt_p1, skid_imm_p1, skid_tgt_p1;
    logic [3*N_LANES-1:0]    fmt_p1, skid_fmt_p1;

    always_ff @(posedge clk) begin
        if (load_main) begin
            imm_p1 <= imm_p0;
            fmt_p1 <= fmt_p0;
            tgt_p1 <= tgt_p0;
        end else if (pop_skid) begin
            imm_p1 <= skid_imm_p1;
            fmt_p1 <= skid_fmt_p1;
            tgt_p1 <= skid_tgt_p1;
        end
        if (load_skid) begin
            skid_imm_p1 <= imm_p0;
            skid_fmt_p1 <= fmt_p0;
            skid_tgt_p1 <= tgt_p0;
        end
    end

    // Data registers carry no reset; outputs read as zero whenever nothing is held
    assign out_valid  = vld_p1;
    assign out_imm    = vld_p1 ? imm_p1 : '0;
    assign out_fmt    = vld_p1 ? fmt_p1 : '0;
    assign out_target = vld_p1 ? tgt_p1 : '0;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: vector table across RV32 dual-lane and
// RV64 (with and without CSR) instances, plus backpressure and reset sequences.
module tb_imm_gen_pipe;
    import imm_gen_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [63:0] instr2;
    logic [63:0] pc64;

    logic        rdy32, vld32;
    logic [63:0] imm32, tgt32;
    logic [5:0]  fmt32;
    logic        rdy64, vld64;
    logic [63:0] imm64, tgt64;
    logic [2:0]  fmt64;
    logic        rdyn, vldn;
    logic [63:0] immn, tgtn;
    logic [2:0]  fmtn;

    int errors = 0;
    int checks = 0;

    initial forever #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .N_LANES(2), .EN_CSR(1)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32),
        .in_instr(instr2), .in_pc(pc64[31:0]), .out_valid(vld32), .out_ready(out_ready),
        .out_imm(imm32), .out_fmt(fmt32), .out_target(tgt32)
    );

    imm_gen_pipe #(.XLEN(64), .N_LANES(1), .EN_CSR(1)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy64),
        .in_instr(instr2[31:0]), .in_pc(pc64), .out_valid(vld64), .out_ready(out_ready),
        .out_imm(imm64), .out_fmt(fmt64), .out_target(tgt64)
    );

    imm_gen_pipe #(.XLEN(64), .N_LANES(1), .EN_CSR(0)) dut64n (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdyn),
        .in_instr(instr2[31:0]), .in_pc(pc64), .out_valid(vldn), .out_ready(out_ready),
        .out_imm(immn), .out_fmt(fmtn), .out_target(tgtn)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] addi(input int k);
        return {12'(k), 20'h00093};
    endfunction

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        fmt_t        fmt;
        fmt_t        fmtn;
        logic [31:0] imm32;
        logic [31:0] tgt32;
        logic [63:0] imm64;
        logic [63:0] tgt64;
        logic [63:0] immn;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs[NV];

    int          sent, got;
    logic        held;
    logic [63:0] held_imm;

    initial begin
        vecs[0]  = '{32'hFFF00093, 64'h0, FMT_I, FMT_I, 32'hFFFFFFFF, 32'h0,
                     64'hFFFFFFFF_FFFFFFFF, 64'h0, 64'hFFFFFFFF_FFFFFFFF};
        vecs[1]  = '{32'h01F09093, 64'h0, FMT_SHAMT, FMT_SHAMT, 32'h1F, 32'h0, 64'h1F, 64'h0, 64'h1F};
        vecs[2]  = '{32'h03F09093, 64'h0, FMT_SHAMT, FMT_SHAMT, 32'h1F, 32'h0, 64'h3F, 64'h0, 64'h3F};
        vecs[3]  = '{32'h4010D093, 64'h0, FMT_SHAMT, FMT_SHAMT, 32'h1, 32'h0, 64'h1, 64'h0, 64'h1};
        vecs[4]  = '{32'hFE000EE3, 64'h100, FMT_B, FMT_B, 32'hFFFFFFFC, 32'hFC,
                     64'hFFFFFFFF_FFFFFFFC, 64'hFC, 64'hFFFFFFFF_FFFFFFFC};
        vecs[5]  = '{32'h00000863, 64'hFFFFFFF0, FMT_B, FMT_B, 32'h10, 32'h0,
                     64'h10, 64'h1_00000000, 64'h10};
        vecs[6]  = '{32'h0080006F, 64'h200, FMT_J, FMT_J, 32'h8, 32'h208, 64'h8, 64'h208, 64'h8};
        vecs[7]  = '{32'h800000B7, 64'h40, FMT_U, FMT_U, 32'h80000000, 32'h0,
                     64'hFFFFFFFF_80000000, 64'h0, 64'hFFFFFFFF_80000000};
        vecs[8]  = '{32'h00001017, 64'h1000, FMT_U, FMT_U, 32'h1000, 32'h2000, 64'h1000, 64'h2000, 64'h1000};
        vecs[9]  = '{32'h3002D073, 64'h40, FMT_CSR, FMT_NONE, 32'h5, 32'h0, 64'h5, 64'h0, 64'h0};
        vecs[10] = '{32'hFE112E23, 64'h40, FMT_S, FMT_S, 32'hFFFFFFFC, 32'h0,
                     64'hFFFFFFFF_FFFFFFFC, 64'h0, 64'hFFFFFFFF_FFFFFFFC};
        vecs[11] = '{32'h00412083, 64'h40, FMT_I, FMT_I, 32'h4, 32'h0, 64'h4, 64'h0, 64'h4};
        vecs[12] = '{32'h008000E7, 64'h40, FMT_I, FMT_I, 32'h8, 32'h0, 64'h8, 64'h0, 64'h8};
        vecs[13] = '{32'h00000033, 64'h40, FMT_NONE, FMT_NONE, 32'h0, 32'h0, 64'h0, 64'h0, 64'h0};
        vecs[14] = '{32'h00000073, 64'h40, FMT_NONE, FMT_NONE, 32'h0, 32'h0, 64'h0, 64'h0, 64'h0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        instr2 = 64'h0; pc64 = 64'h0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(vld32), 64'h0);
        chk("rst_in_ready", 64'(rdy32), 64'h0);
        chk("rst_out_imm", imm32, 64'h0);
        chk("rst_out_fmt", 64'(fmt32), 64'h0);
        chk("rst_out_target", tgt32, 64'h0);
        chk("rst_out_valid64", 64'(vld64), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", 64'(rdy32), 64'h1);

        // vector table, lane 1 carries a nop
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            instr2 = {32'h00000013, vecs[i].instr};
            pc64 = vecs[i].pc;
            in_valid = 1'b1;
            out_ready = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            chk($sformatf("v%0d_valid", i), 64'(vld32), 64'h1);
            chk($sformatf("v%0d_imm32", i), 64'(imm32[31:0]), 64'(vecs[i].imm32));
            chk($sformatf("v%0d_fmt32", i), 64'(fmt32[2:0]), 64'(vecs[i].fmt));
            chk($sformatf("v%0d_tgt32", i), 64'(tgt32[31:0]), 64'(vecs[i].tgt32));
            chk($sformatf("v%0d_l1_fmt", i), 64'(fmt32[5:3]), 64'(FMT_I));
            chk($sformatf("v%0d_l1_tgt", i), 64'(tgt32[63:32]), 64'h0);
            chk($sformatf("v%0d_imm64", i), imm64, vecs[i].imm64);
            chk($sformatf("v%0d_fmt64", i), 64'(fmt64), 64'(vecs[i].fmt));
            chk($sformatf("v%0d_tgt64", i), tgt64, vecs[i].tgt64);
            chk($sformatf("v%0d_immn", i), immn, vecs[i].immn);
            chk($sformatf("v%0d_fmtn", i), 64'(fmtn), 64'(vecs[i].fmtn));
        end

        // dual lane: lane 1 PC wraps to 0, jal +8 lands on 8
        @(negedge clk);
        instr2 = {32'h0080006F, 32'h00000013};
        pc64 = 64'hFFFFFFFC;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("wrap_l1_imm", 64'(imm32[63:32]), 64'h8);
        chk("wrap_l1_fmt", 64'(fmt32[5:3]), 64'(FMT_J));
        chk("wrap_l1_tgt", 64'(tgt32[63:32]), 64'h8);
        chk("wrap_l0_tgt", 64'(tgt32[31:0]), 64'h0);

        // dual lane: lane 1 branch -4 from pc 0x104
        @(negedge clk);
        instr2 = {32'hFE000EE3, 32'h00000013};
        pc64 = 64'h100;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("l1pc_tgt", 64'(tgt32[63:32]), 64'h100);
        chk("l1pc_fmt", 64'(fmt32[5:3]), 64'(FMT_B));

        // backpressure: 4 bundles, out_ready low in cycles 2..4
        sent = 0; got = 0; held = 1'b0; held_imm = 64'h0;
        pc64 = 64'h0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            in_valid = (sent < 4);
            instr2 = {32'h00000013, addi(sent + 1)};
            out_ready = !(c >= 2 && c <= 4);
            #1;
            if (c == 3) chk("bp_in_ready_skid", 64'(rdy32), 64'h0);
            if (held && vld32) chk("bp_stable", imm32, held_imm);
            if (vld32 && out_ready) begin
                chk("bp_order", 64'(imm32[31:0]), 64'(got + 1));
                got++;
            end
            held = vld32 && !out_ready;
            held_imm = imm32;
            if (in_valid && rdy32) sent++;
        end
        in_valid = 1'b0;
        chk("bp_sent", 64'(sent), 64'd4);
        chk("bp_got", 64'(got), 64'd4);
        chk("bp_idle", 64'(vld32), 64'h0);

        // reset while both main and skid are occupied
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1;
        instr2 = {32'h00000013, addi(85)};
        @(negedge clk);
        instr2 = {32'h00000013, addi(102)};
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("rs_skid_in_ready", 64'(rdy32), 64'h0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rs_out_valid", 64'(vld32), 64'h0);
        chk("rs_in_ready", 64'(rdy32), 64'h0);
        chk("rs_out_imm", imm32, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("rs_rel_in_ready", 64'(rdy32), 64'h1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rs_no_stale", 64'(vld32), 64'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
